// File: rtl/madd_eval_pkg.sv
// Shared types and sizes for the multiply-add evaluation sweeper.
// Holds the FSM state encoding, operand/result widths and accumulator widths.
package madd_eval_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } state_t;

    localparam int unsigned OP_W      = 2;
    localparam int unsigned RES_W     = 4;
    localparam int unsigned VEC_W     = 3 * OP_W;
    localparam int unsigned VEC_COUNT = 64;
    localparam int unsigned CNT_W     = 7;
    localparam int unsigned SUM_W     = 10;

    // Magnitude of (x - y), computed with one extra sign bit so no wrap occurs.
    function automatic logic [RES_W-1:0] abs_diff(input logic [RES_W-1:0] x,
                                                  input logic [RES_W-1:0] y);
        logic signed [RES_W:0] d;
        logic signed [RES_W:0] m;
        d = $signed({1'b0, x}) - $signed({1'b0, y});
        m = d[RES_W] ? -d : d;
        return m[RES_W-1:0];
    endfunction

endpackage

// File: rtl/madd_exact_ref.sv
// Combinational golden model: exact = a*b + c on the 2-bit fields of vec.
// Field order is a = vec[1:0], b = vec[3:2], c = vec[5:4].
module madd_exact_ref
    import madd_eval_pkg::*;
(
    input  logic [VEC_W-1:0] vec,
    output logic [RES_W-1:0] exact
);

    logic [RES_W-1:0] a;
    logic [RES_W-1:0] b;
    logic [RES_W-1:0] c;

    always_comb begin
        a     = {{(RES_W-OP_W){1'b0}}, vec[OP_W-1:0]};
        b     = {{(RES_W-OP_W){1'b0}}, vec[2*OP_W-1:OP_W]};
        c     = {{(RES_W-OP_W){1'b0}}, vec[3*OP_W-1:2*OP_W]};
        exact = a * b + c;
    end

endmodule

// File: rtl/madd_eval_sweeper.sv
// Exhaustive error sweeper for an approximate 2x2+2 multiply-add circuit.
// Drives all 64 input vectors, one per cycle, and accumulates error statistics.
module madd_eval_sweeper
    import madd_eval_pkg::*;
#(
    parameter int unsigned ET = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [VEC_W-1:0] vec,
    input  logic [RES_W-1:0] approx_out,
    output logic             busy,
    output logic             done,
    output logic [RES_W-1:0] max_err,
    output logic [CNT_W-1:0] err_count,
    output logic [SUM_W-1:0] sum_err,
    output logic             pass,
    output logic             valid
);

    state_t           state;
    state_t           state_next;
    logic [RES_W-1:0] exact;
    logic [RES_W-1:0] err_abs;
    logic             last_vec;

    madd_exact_ref u_exact_ref (
        .vec   (vec),
        .exact (exact)
    );

    assign err_abs  = abs_diff(approx_out, exact);
    assign last_vec = (vec == VEC_W'(VEC_COUNT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SWEEP;
                end
            end
            SWEEP: begin
                busy = 1'b1;
                if (abort) begin
                    state_next = IDLE;
                end else if (last_vec) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // vec wraps to 0 on its own after the 63rd vector, ready for the next sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec       <= '0;
            max_err   <= '0;
            err_count <= '0;
            sum_err   <= '0;
            valid     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        vec       <= '0;
                        max_err   <= '0;
                        err_count <= '0;
                        sum_err   <= '0;
                        valid     <= 1'b0;
                    end
                end
                SWEEP: begin
                    if (abort) begin
                        vec   <= '0;
                        valid <= 1'b0;
                    end else begin
                        vec     <= vec + 1'b1;
                        sum_err <= sum_err + {{(SUM_W-RES_W){1'b0}}, err_abs};
                        if (err_abs > max_err) begin
                            max_err <= err_abs;
                        end
                        if (32'(err_abs) > ET) begin
                            err_count <= err_count + 1'b1;
                        end
                        if (last_vec) begin
                            valid <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign pass = valid && (err_count == '0);

endmodule

// File: tb/tb_madd_eval_sweeper.sv
// Self-checking bench for madd_eval_sweeper with a behavioural approximate circuit.
// Table-driven full sweeps plus directed abort, start-ignore and reset sequences.
module tb_madd_eval_sweeper;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [5:0] vec;
    logic [3:0] approx_out;
    logic       busy;
    logic       done;
    logic [3:0] max_err;
    logic [6:0] err_count;
    logic [9:0] sum_err;
    logic       pass;
    logic       valid;

    int checks = 0;
    int errors = 0;
    int mode   = 0;

    madd_eval_sweeper #(.ET(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .vec        (vec),
        .approx_out (approx_out),
        .busy       (busy),
        .done       (done),
        .max_err    (max_err),
        .err_count  (err_count),
        .sum_err    (sum_err),
        .pass       (pass),
        .valid      (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int madd_model(input logic [5:0] v);
        return int'(v[1:0]) * int'(v[3:2]) + int'(v[5:4]);
    endfunction

    // Approximate circuit under test: 0 exact, 1 stuck-at-0, 2 exact+1, 3 stuck-at-15
    always_comb begin
        case (mode)
            0:       approx_out = 4'(madd_model(vec));
            1:       approx_out = 4'd0;
            2:       approx_out = 4'(madd_model(vec) + 1);
            default: approx_out = 4'd15;
        endcase
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pulse start for one edge, then count edges until done (bounded).
    task automatic run_sweep(output int edges);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
        check("vec_after_start", int'(vec), 0);
        check("valid_cleared", int'(valid), 0);
        edges = 0;
        while (!done && edges < 200) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    typedef struct {
        int mode;
        int exp_max;
        int exp_cnt;
        int exp_sum;
        int exp_pass;
    } vec_t;

    vec_t tbl[4];
    int   edges;
    int   saw_done;

    initial begin
        tbl[0] = '{mode: 0, exp_max: 0,  exp_cnt: 0,  exp_sum: 0,   exp_pass: 1};
        tbl[1] = '{mode: 1, exp_max: 12, exp_cnt: 6,  exp_sum: 240, exp_pass: 0};
        tbl[2] = '{mode: 2, exp_max: 1,  exp_cnt: 0,  exp_sum: 64,  exp_pass: 1};
        tbl[3] = '{mode: 3, exp_max: 15, exp_cnt: 53, exp_sum: 720, exp_pass: 0};

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        #12;
        check("rst_vec", int'(vec), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_sum", int'(sum_err), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_pass", int'(pass), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            mode = tbl[i].mode;
            run_sweep(edges);
            check("done_edge", edges, 64);
            check("done_busy", int'(busy), 0);
            check("done_valid", int'(valid), 1);
            check("done_vec_wrap", int'(vec), 0);
            check("max_err", int'(max_err), tbl[i].exp_max);
            check("err_count", int'(err_count), tbl[i].exp_cnt);
            check("sum_err", int'(sum_err), tbl[i].exp_sum);
            check("pass", int'(pass), tbl[i].exp_pass);
            @(posedge clk); #1;
            check("done_one_cycle", int'(done), 0);
            check("hold_sum", int'(sum_err), tbl[i].exp_sum);
            check("hold_valid", int'(valid), 1);
        end

        // abort outside SWEEP leaves results untouched
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("idle_abort_valid", int'(valid), 1);
        check("idle_abort_sum", int'(sum_err), 720);

        // abort at vec=20, asserted together with start to confirm priority
        mode  = 1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
        end
        check("abort_at_vec", int'(vec), 20);
        abort = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        start = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_vec", int'(vec), 0);
        check("abort_valid", int'(valid), 0);
        check("abort_pass", int'(pass), 0);
        saw_done = 0;
        for (int k = 0; k < 70; k++) begin
            if (done) saw_done = 1;
            @(posedge clk); #1;
        end
        check("abort_no_done", saw_done, 0);
        check("abort_stays_idle", int'(busy), 0);

        // start held during SWEEP must not stretch or restart the sweep
        mode  = 2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 0;
        while (!done && edges < 200) begin
            start = (edges >= 10 && edges < 13) || edges == 62;
            @(posedge clk); #1;
            edges++;
        end
        start = 1'b0;
        check("start_ignored_len", edges, 64);
        check("start_ignored_sum", int'(sum_err), 64);
        // start in DONE is ignored; the very next IDLE cycle accepts it
        start = 1'b1;
        @(posedge clk); #1;
        check("start_in_done_ignored", int'(busy), 0);
        @(posedge clk); #1;
        start = 1'b0;
        check("start_after_done", int'(busy), 1);
        check("start_after_done_vec", int'(vec), 0);

        // asynchronous reset mid-sweep at vec=40
        mode = 1;
        while (vec != 6'd40 && busy) begin
            @(posedge clk); #1;
        end
        check("reset_at_vec", int'(vec), 40);
        #2 rst_n = 1'b0;
        #1;
        check("arst_vec", int'(vec), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        check("arst_max", int'(max_err), 0);
        check("arst_cnt", int'(err_count), 0);
        check("arst_sum", int'(sum_err), 0);
        check("arst_valid", int'(valid), 0);
        check("arst_pass", int'(pass), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_sweep(edges);
        check("post_rst_edge", edges, 64);
        check("post_rst_max", int'(max_err), 12);
        check("post_rst_cnt", int'(err_count), 6);
        check("post_rst_sum", int'(sum_err), 240);
        check("post_rst_pass", int'(pass), 0);
        check("post_rst_valid", int'(valid), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/madd_eval_sweeper.md
MADD_EVAL_SWEEPER -- requirements
Module: madd_eval_sweeper

Interface
REQ-001 The block SHALL have parameter ET, default 8, the error threshold; vectors with |error| > ET count as violations.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a full evaluation sweep.
REQ-005 The block SHALL have port abort, input, 1 bit: cancel a sweep in progress.
REQ-006 The block SHALL have port vec, output, 6 bits: stimulus driven to the approximate circuit under test, bit i to in<i>.
REQ-007 The block SHALL have port approx_out, input, 4 bits: circuit-under-test response, bit i from out<i>, combinational from vec.
REQ-008 The block SHALL have port busy, output, 1 bit: sweep in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse when a sweep completes.
REQ-010 The block SHALL have port max_err, output, 4 bits: largest |error| over the sweep.
REQ-011 The block SHALL have port err_count, output, 7 bits: number of violating vectors (0..64).
REQ-012 The block SHALL have port sum_err, output, 10 bits: sum of |error| over all vectors (max 960).
REQ-013 The block SHALL have port pass, output, 1 bit: 1 when err_count==0 for the last completed sweep.
REQ-014 The block SHALL have port valid, output, 1 bit: results reflect a completed, unaborted sweep.

Function
REQ-015 Exact value SHALL be a*b+c, where a=vec[1:0], b=vec[3:2], c=vec[5:4], unsigned, 4-bit result (max 12).
REQ-016 Error SHALL be |approx_out - exact|, computed in 5-bit signed arithmetic, then magnitude in 4 bits.
REQ-017 The FSM SHALL have states IDLE, SWEEP and DONE.
REQ-018 In IDLE, start=1 at an edge SHALL enter SWEEP with vec=0, clear max_err/err_count/sum_err/valid, and set busy=1.
REQ-019 In SWEEP, at each edge the error for the current vec SHALL be accumulated and vec SHALL increment by 1; one vector per cycle.
REQ-020 At the edge accumulating vec=63, the FSM SHALL enter DONE; vec wraps to 0 and the accumulators hold final values.
REQ-021 DONE SHALL last exactly one cycle with done=1, busy=0 and valid=1, then return to IDLE; done is asserted 64 edges after the start edge.
REQ-022 In IDLE, results SHALL hold until the next accepted start.
REQ-023 start during SWEEP or DONE SHALL be ignored; start in the IDLE cycle after DONE SHALL be accepted.
REQ-024 abort=1 in SWEEP SHALL return to IDLE at that edge with no accumulation, done not pulsed, valid=0, vec=0.
REQ-025 abort SHALL take priority over start; abort outside SWEEP SHALL have no effect.
REQ-026 max_err SHALL update as max(max_err, |error|); err_count SHALL increment when |error| > ET; sum_err SHALL add |error|; none saturate, since widths cover worst case.
REQ-027 pass SHALL be combinational from err_count==0 and valid; pass=0 whenever valid=0.

Reset
REQ-028 When rst_n=0, the block SHALL asynchronously set state=IDLE, vec=0, busy=0, done=0, max_err=0, err_count=0, sum_err=0, valid=0 and pass=0.
REQ-029 Reset mid-sweep SHALL discard partial results; the first start after release SHALL run a full 64-vector sweep.

Structure
REQ-030 Package madd_eval_pkg SHALL hold the FSM state enum, operand width (2), result width (4), vector count (64), and the err_count/sum_err widths.
REQ-031 Sub-module madd_exact_ref SHALL be a purely combinational exact a*b+c model used for the comparison.
REQ-032 The block SHALL instantiate no circuit under test; the bench connects the approximate circuit between vec and approx_out.

Verification
REQ-033 The bench SHALL cover: exact model as DUT, start -> done at 64th edge, max_err=0, err_count=0, sum_err=0, pass=1.
REQ-034 The bench SHALL cover: DUT stuck at 0 -> max_err=12, err_count=6, sum_err=240, pass=0.
REQ-035 The bench SHALL cover: DUT = exact+1 -> max_err=1, err_count=0, sum_err=64, pass=1.
REQ-036 The bench SHALL cover: DUT stuck at 15 -> max_err=15, sum_err=720, pass=0.
REQ-037 The bench SHALL cover: abort at vec=20 -> IDLE next edge, no done pulse, valid=0, vec=0; start during SWEEP -> sweep length unchanged (64).
REQ-038 The bench SHALL cover: rst_n low at vec=40 -> all outputs 0 immediately; restart -> results identical to an uninterrupted sweep.
